// File: rtl/text_row_renderer_pkg.sv
// Shared types and widths for the text-mode row renderer.
package text_row_renderer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned CG_ADDR_W   = 10;
  localparam int unsigned CG_ROW_W    = 4;
  localparam int unsigned VRAM_ADDR_W = 9;
  localparam int unsigned INV_BIT     = 7;
  localparam int unsigned CHAR_W      = 8;
  localparam int unsigned GLYPH_W     = 6;
  localparam int unsigned PX_W        = 3;

  // charGen address: glyph index in the upper bits, scanline within the cell below.
  function automatic logic [CG_ADDR_W-1:0] cg_address(input logic [GLYPH_W-1:0] glyph,
                                                      input logic [CG_ROW_W-1:0] row);
    return {glyph, row};
  endfunction

endpackage

// File: rtl/text_row_renderer_pixel_shift8.sv
// 8-bit parallel-load serializer; MSB is the current pixel, zeros shift in.
module pixel_shift8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       msb
);

  logic [7:0] q;

  // Clear wins over load, load wins over shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[6:0], 1'b0};
    end
  end

  assign msb = q[7];

endmodule

// File: rtl/text_row_renderer.sv
// Text-mode row renderer: fetches char codes, addresses charGen and serializes glyph rows.
module text_row_renderer
  import text_row_renderer_pkg::*;
#(
  parameter int unsigned COLS           = 32,
  parameter int unsigned ROWS           = 16,
  parameter int unsigned LINES_PER_CHAR = 12,
  parameter int unsigned VRAM_BASE      = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   line_start,
  output logic                   vram_re,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  input  logic [CHAR_W-1:0]      vram_data,
  output logic [CG_ADDR_W-1:0]   cg_addr,
  input  logic [CHAR_W-1:0]      cg_data,
  output logic                   pix,
  output logic                   pix_en
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [PX_W-1:0]     px;
  logic [CG_ROW_W-1:0] line_row;
  logic [CG_ROW_W-1:0] lr_base;
  logic [CG_ROW_W-1:0] lr_next;
  logic [ROW_W-1:0]    char_row;
  logic [ROW_W-1:0]    cr_base;
  logic [ROW_W-1:0]    cr_next;
  logic [CHAR_W-1:0]   char_q;
  logic [CHAR_W-1:0]   glyph;
  logic                last_px;
  logic                line_done;
  logic                sh_clear;
  logic                sh_load;
  logic                sh_shift;
  logic                unused_char_bits;

  // VRAM address of a character cell in the given text row.
  function automatic logic [VRAM_ADDR_W-1:0] fetch_addr(input logic [ROW_W-1:0] r,
                                                        input logic [COL_W-1:0] c);
    return VRAM_ADDR_W'(VRAM_BASE + 32'(r) * COLS + 32'(c));
  endfunction

  // Row bookkeeping (frame_start clears before any advance) and serializer control.
  always_comb begin
    last_px   = (px == PX_W'(7));
    lr_base   = frame_start ? '0 : line_row;
    cr_base   = frame_start ? '0 : char_row;
    line_done = (state == DRAIN) && last_px && !line_start;
    lr_next   = lr_base;
    cr_next   = cr_base;
    if (line_done) begin
      if (lr_base == CG_ROW_W'(LINES_PER_CHAR - 1)) begin
        lr_next = '0;
        cr_next = (cr_base == ROW_W'(ROWS - 1)) ? '0 : cr_base + ROW_W'(1);
      end else begin
        lr_next = lr_base + CG_ROW_W'(1);
      end
    end
    glyph    = cg_data ^ {CHAR_W{char_q[INV_BIT]}};
    sh_clear = line_start || ((state == DRAIN) && last_px);
    sh_load  = (state == FETCH) && last_px;
    sh_shift = (state != IDLE);
  end

  // Only the inverse-video bit of the latched code is needed after the charGen address is formed.
  assign unused_char_bits = ^char_q[INV_BIT-1:0];

  // Slot sequencer: one 8-cycle slot per column, then a drain slot for the last glyph.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      px        <= '0;
      line_row  <= '0;
      char_row  <= '0;
      char_q    <= '0;
      vram_re   <= 1'b0;
      vram_addr <= '0;
      cg_addr   <= '0;
      pix_en    <= 1'b0;
    end else begin
      line_row <= lr_next;
      char_row <= cr_next;
      vram_re  <= 1'b0;
      if (line_start) begin
        state     <= FETCH;
        col       <= '0;
        px        <= '0;
        vram_re   <= 1'b1;
        vram_addr <= fetch_addr(cr_base, COL_W'(0));
        pix_en    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          FETCH: begin
            px <= px + PX_W'(1);
            if (px == PX_W'(1)) begin
              char_q  <= vram_data;
              cg_addr <= cg_address(vram_data[GLYPH_W-1:0], lr_base);
            end
            if (last_px) begin
              pix_en <= 1'b1;
              if (col == COL_W'(COLS - 1)) begin
                state <= DRAIN;
                col   <= '0;
              end else begin
                col       <= col + COL_W'(1);
                vram_re   <= 1'b1;
                vram_addr <= fetch_addr(cr_base, col + COL_W'(1));
              end
            end
          end
          DRAIN: begin
            px <= px + PX_W'(1);
            if (last_px) begin
              state  <= IDLE;
              pix_en <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  pixel_shift8 u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (sh_clear),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (glyph),
    .msb     (pix)
  );

endmodule

// File: tb/tb_text_row_renderer.sv
// Directed bench for text_row_renderer with a VRAM model and a charGen model.
module tb_text_row_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_start;
  logic       line_start;
  logic       vram_re;
  logic [8:0] vram_addr;
  logic [7:0] vram_data;
  logic [9:0] cg_addr;
  logic [7:0] cg_data;
  logic       pix;
  logic       pix_en;

  logic [7:0] vram [512];
  logic [7:0] vram_code;
  logic [8:0] first_addr;
  int         errors = 0;
  int         checks = 0;
  int         lr = 0;
  int         cr = 0;

  typedef struct {
    logic [7:0] code;
    int         row;
    logic [7:0] exp_glyph;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  text_row_renderer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .vram_re     (vram_re),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .cg_addr     (cg_addr),
    .cg_data     (cg_data),
    .pix         (pix),
    .pix_en      (pix_en)
  );

  // Synchronous video RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (vram_re) vram_data <= vram[vram_addr];
  end

  // charGen stand-in: rows 0-2 and 10+ blank, otherwise a pattern of glyph and row.
  function automatic logic [7:0] cg_model(input logic [9:0] a);
    if (a[3:0] < 4'd3 || a[3:0] >= 4'd10) return 8'h00;
    return a[7:0] ^ 8'h1B ^ {6'b0, a[9:8]};
  endfunction

  assign cg_data = cg_model(cg_addr);

  function automatic logic [7:0] glyph_of(input logic inv, input logic [5:0] g, input int row);
    return cg_model({g, 4'(row)}) ^ {8{inv}};
  endfunction

  task automatic fill(input logic [7:0] code);
    vram_code = code;
    for (int i = 0; i < 512; i++) vram[i] = code;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic report(input string name, input int bad, input int at,
                        input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad cycles, first at T+%0d got %0h expected %0h", name, bad, at, got, want);
    end
  endtask

  task automatic advance();
    if (lr == 11) begin
      lr = 0;
      cr = (cr == 15) ? 0 : cr + 1;
    end else begin
      lr++;
    end
  endtask

  // One scanline from line_start; fs_at pulses frame_start mid-line, stop_at ends early.
  task automatic run_line(input string name, input logic fs, input logic [7:0] g_old,
                          input int fs_at, input int stop_at);
    int bad_pix, bad_en, bad_re, k_pix, k_en, k_re, c, b, col, arow;
    logic [15:0] got_pix, want_pix, got_en, want_en, got_re, want_re;
    logic [7:0] g_new, g;
    logic exp_en, exp_pix, exp_re;
    logic [8:0] exp_addr;
    bad_pix = 0; bad_en = 0; bad_re = 0; k_pix = 0; k_en = 0; k_re = 0;
    got_pix = '0; want_pix = '0; got_en = '0; want_en = '0; got_re = '0; want_re = '0;
    line_start  = 1'b1;
    frame_start = fs;
    if (fs) begin
      lr = 0;
      cr = 0;
    end
    g_new = glyph_of(vram_code[7], vram_code[5:0], 0);
    for (int k = 1; k <= 266; k++) begin
      @(negedge clk);
      if (k == 1) begin
        line_start  = 1'b0;
        frame_start = 1'b0;
      end
      if (fs_at != 0 && k == fs_at + 1) frame_start = 1'b0;
      exp_en  = (k >= 9 && k <= 264);
      exp_pix = 1'b0;
      if (exp_en) begin
        c = (k - 9) / 8;
        b = (k - 9) % 8;
        g = (fs_at != 0 && fs_at <= 2 + 8 * c) ? g_new : g_old;
        exp_pix = g[3'(7 - b)];
      end
      col      = (k - 1) / 8;
      exp_re   = (k <= 249) && ((k - 1) % 8 == 0);
      arow     = (fs_at != 0 && fs_at <= 8 * col) ? 0 : cr;
      exp_addr = 9'(arow * 32 + col);
      if (k == 1) first_addr = vram_addr;
      if (pix !== exp_pix) begin
        if (bad_pix == 0) begin k_pix = k; got_pix = 16'(pix); want_pix = 16'(exp_pix); end
        bad_pix++;
      end
      if (pix_en !== exp_en) begin
        if (bad_en == 0) begin k_en = k; got_en = 16'(pix_en); want_en = 16'(exp_en); end
        bad_en++;
      end
      if (vram_re !== exp_re || (exp_re && vram_addr !== exp_addr)) begin
        if (bad_re == 0) begin
          k_re = k;
          got_re = {vram_re, 6'b0, vram_addr};
          want_re = {exp_re, 6'b0, exp_addr};
        end
        bad_re++;
      end
      if (fs_at != 0 && k == fs_at) frame_start = 1'b1;
      if (k == stop_at) break;
    end
    report({name, " pix"}, bad_pix, k_pix, got_pix, want_pix);
    report({name, " pix_en"}, bad_en, k_en, got_en, want_en);
    report({name, " fetch"}, bad_re, k_re, got_re, want_re);
    if (stop_at == 0) begin
      if (fs_at != 0) begin
        lr = 0;
        cr = 0;
      end
      advance();
    end
  endtask

  initial begin
    int bad_idle;
    vecs[0] = '{8'h01, 3, 8'h08};
    vecs[1] = '{8'h81, 3, 8'hF7};
    vecs[2] = '{8'h41, 3, 8'h08};
    vecs[3] = '{8'h05, 7, 8'h4C};
    vecs[4] = '{8'h85, 7, 8'hB3};
    vecs[5] = '{8'h3F, 9, 8'hE1};
    vecs[6] = '{8'h81, 0, 8'hFF};
    vecs[7] = '{8'h02, 10, 8'h00};

    reset_n = 1'b0;
    frame_start = 1'b0;
    line_start = 1'b0;
    vram_data = 8'h00;
    fill(8'h00);
    repeat (3) @(negedge clk);
    chk("reset pix", 16'(pix), 16'h0);
    chk("reset pix_en", 16'(pix_en), 16'h0);
    chk("reset vram_re", 16'(vram_re), 16'h0);
    chk("reset cg_addr", 16'(cg_addr), 16'h0);
    chk("reset vram_addr", 16'(vram_addr), 16'h0);
    reset_n = 1'b1;

    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pix !== 1'b0 || pix_en !== 1'b0 || vram_re !== 1'b0) bad_idle++;
    end
    report("idle outputs", bad_idle, 0, 16'(bad_idle), 16'h0);

    // Table vectors: render up to the target row and compare against the hand value.
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].code);
      for (int l = 0; l <= vecs[i].row; l++) begin
        run_line($sformatf("vec%0d line%0d", i, l), l == 0,
                 (l == vecs[i].row) ? vecs[i].exp_glyph
                                    : glyph_of(vecs[i].code[7], vecs[i].code[5:0], l),
                 0, 0);
      end
    end

    // Text-row advance and frame wrap of the fetch address.
    fill(8'h01);
    for (int l = 0; l <= 192; l++) begin
      run_line($sformatf("wrap line%0d", l), l == 0,
               glyph_of(1'b0, 6'h01, (l == 0) ? 0 : lr), 0, 0);
      if (l == 12) chk("addr after 12 lines", 16'(first_addr), 16'd32);
      if (l == 192) chk("addr after 192 lines", 16'(first_addr), 16'd0);
    end

    // Abort/restart, then frame_start mid-line.
    fill(8'h85);
    for (int l = 0; l <= 16; l++) begin
      run_line($sformatf("pre line%0d", l), l == 0, glyph_of(1'b1, 6'h05, (l == 0) ? 0 : lr), 0, 0);
    end
    run_line("aborted", 1'b0, glyph_of(1'b1, 6'h05, lr), 0, 84);
    run_line("restarted", 1'b0, glyph_of(1'b1, 6'h05, lr), 0, 0);
    run_line("mid frame", 1'b0, glyph_of(1'b1, 6'h05, lr), 100, 0);
    for (int l = 0; l < 3; l++) begin
      run_line($sformatf("post frame%0d", l), 1'b0, glyph_of(1'b1, 6'h05, lr), 0, 0);
    end

    // Asynchronous reset mid-slot 5, then a fresh frame.
    fill(8'h01);
    for (int l = 0; l < 3; l++) begin
      run_line($sformatf("pre reset%0d", l), l == 0, glyph_of(1'b0, 6'h01, (l == 0) ? 0 : lr), 0, 0);
    end
    run_line("cut line", 1'b0, glyph_of(1'b0, 6'h01, lr), 0, 43);
    reset_n = 1'b0;
    #1;
    chk("async pix", 16'(pix), 16'h0);
    chk("async pix_en", 16'(pix_en), 16'h0);
    chk("async vram_re", 16'(vram_re), 16'h0);
    chk("async cg_addr", 16'(cg_addr), 16'h0);
    chk("async vram_addr", 16'(vram_addr), 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int l = 0; l <= 3; l++) begin
      run_line($sformatf("after reset%0d", l), l == 0,
               (l == 3) ? 8'h08 : glyph_of(1'b0, 6'h01, l), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
